// File: rtl/fc_bb_credit_mgr_if.sv
// Signal bundle between the BB credit manager and the FC MAC / transmit encoder.
// master = credit manager view, slave = MAC/encoder view.
interface fc_bb_credit_mgr_if #(
  parameter int unsigned CREDIT_W = 16,
  parameter int unsigned BBSC_W   = 4
) ();
  logic [CREDIT_W-1:0] credit;
  logic [BBSC_W-1:0]   bb_scn;
  logic                credit_reset;
  logic                credit_reset_ack;
  logic                tx_frm_sent;
  logic                rx_rdy;
  logic                rx_frm_rcv;
  logic                rx_bb_scs;
  logic                rx_bb_scr;
  logic                buf_release;
  logic                ext_rdy_gen;
  logic                rdy_gen;
  logic [1:0]          tx_prim_req;
  logic                tx_prim_ack;
  logic                tx_allow;
  logic [CREDIT_W-1:0] current_credit;
  logic                rdy_deficit;
  logic                frm_deficit;

  modport master (
    input  credit, bb_scn, credit_reset, tx_frm_sent, rx_rdy, rx_frm_rcv,
           rx_bb_scs, rx_bb_scr, buf_release, ext_rdy_gen, rdy_gen, tx_prim_ack,
    output credit_reset_ack, tx_prim_req, tx_allow, current_credit,
           rdy_deficit, frm_deficit
  );

  modport slave (
    output credit, bb_scn, credit_reset, tx_frm_sent, rx_rdy, rx_frm_rcv,
           rx_bb_scs, rx_bb_scr, buf_release, ext_rdy_gen, rdy_gen, tx_prim_ack,
    input  credit_reset_ack, tx_prim_req, tx_allow, current_credit,
           rdy_deficit, frm_deficit
  );
endinterface

// File: rtl/fc_bb_credit_mgr.sv
// FC buffer-to-buffer credit manager with BB_SC_N credit recovery.
// Tracks transmit credit, owed R_RDYs and requests R_RDY / BB_SC_S / BB_SC_R primitives.
module fc_bb_credit_mgr #(
  parameter int unsigned CREDIT_W = 16,
  parameter int unsigned BBSC_W   = 4,
  parameter int unsigned RDY_Q_W  = 8
) (
  input  logic               tx_clk,
  input  logic               reset_tx_clk_n,
  fc_bb_credit_mgr_if.master bus
);

  typedef enum logic [1:0] {
    PRIM_NONE = 2'd0,
    PRIM_RDY  = 2'd1,
    PRIM_SCS  = 2'd2,
    PRIM_SCR  = 2'd3
  } prim_e;

  // Counters are wide enough for the largest legal modulus 2**(2**BBSC_W-1).
  localparam int unsigned CNT_W    = (1 << BBSC_W) - 1;
  localparam int unsigned CR_EXT_W = ((CREDIT_W > CNT_W) ? CREDIT_W : CNT_W) + 2;
  localparam int unsigned RQ_EXT_W = ((RDY_Q_W > CNT_W) ? RDY_Q_W : CNT_W) + 2;
  localparam logic [RQ_EXT_W-1:0] RQ_MAX = RQ_EXT_W'((1 << RDY_Q_W) - 1);

  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [CREDIT_W-1:0] cur_q, cur_d;
  logic [CNT_W-1:0]    tfc_q, tfc_d, trc_q, trc_d, rfc_q, rfc_d, rrc_q, rrc_d;
  logic                scs_pend_q, scs_pend_d, scr_pend_q, scr_pend_d;
  logic [RDY_Q_W-1:0]  pend_q, pend_d;
  logic                rdy_def_q, rdy_def_d, frm_def_q, frm_def_d;
  logic                ack_q, ack_d;
  prim_e               req_q, req_d;

  logic [CNT_W-1:0]    mask, tfc_inc, trc_inc, rfc_inc, rrc_inc, lost_s, lost_r;
  logic                recov_en, load, prim_ack, rdy_sent, rdy_src, scs_evt, scr_evt;
  logic [CR_EXT_W-1:0] cr_sum;
  logic [RQ_EXT_W-1:0] rq_sum;

  always_ff @(posedge tx_clk) begin
    if (!reset_tx_clk_n) begin
      credit_q   <= '0;
      cur_q      <= '0;
      tfc_q      <= '0;
      trc_q      <= '0;
      rfc_q      <= '0;
      rrc_q      <= '0;
      scs_pend_q <= 1'b0;
      scr_pend_q <= 1'b0;
      pend_q     <= '0;
      rdy_def_q  <= 1'b0;
      frm_def_q  <= 1'b0;
      ack_q      <= 1'b0;
      req_q      <= PRIM_NONE;
    end else begin
      credit_q   <= credit_d;
      cur_q      <= cur_d;
      tfc_q      <= tfc_d;
      trc_q      <= trc_d;
      rfc_q      <= rfc_d;
      rrc_q      <= rrc_d;
      scs_pend_q <= scs_pend_d;
      scr_pend_q <= scr_pend_d;
      pend_q     <= pend_d;
      rdy_def_q  <= rdy_def_d;
      frm_def_q  <= frm_def_d;
      ack_q      <= ack_d;
      req_q      <= req_d;
    end
  end

  always_comb begin
    mask     = CNT_W'((32'd1 << bus.bb_scn) - 32'd1);
    recov_en = (bus.bb_scn != '0);
    load     = bus.credit_reset && !ack_q;
    prim_ack = bus.tx_prim_ack && (req_q != PRIM_NONE);
    rdy_sent = prim_ack && (req_q == PRIM_RDY);
    rdy_src  = bus.ext_rdy_gen ? bus.rdy_gen : bus.buf_release;
    scs_evt  = recov_en && bus.rx_bb_scs;
    scr_evt  = recov_en && bus.rx_bb_scr;

    // Increments land before the BB_SC loss computation of the same cycle.
    tfc_inc = (tfc_q + CNT_W'(bus.tx_frm_sent)) & mask;
    trc_inc = (trc_q + CNT_W'(rdy_sent)) & mask;
    rfc_inc = (rfc_q + CNT_W'(bus.rx_frm_rcv)) & mask;
    rrc_inc = (rrc_q + CNT_W'(bus.rx_rdy)) & mask;
    lost_s  = scs_evt ? ((CNT_W'(0) - rfc_inc) & mask) : '0;
    lost_r  = scr_evt ? ((CNT_W'(0) - rrc_inc) & mask) : '0;

    tfc_d = tfc_inc;
    trc_d = trc_inc;
    rfc_d = scs_evt ? '0 : rfc_inc;
    rrc_d = scr_evt ? '0 : rrc_inc;

    scs_pend_d = (recov_en && bus.tx_frm_sent && (tfc_inc == '0))
              || (scs_pend_q && !(prim_ack && (req_q == PRIM_SCS)));
    scr_pend_d = (recov_en && rdy_sent && (trc_inc == '0))
              || (scr_pend_q && !(prim_ack && (req_q == PRIM_SCR)));

    cr_sum = CR_EXT_W'(cur_q) + CR_EXT_W'(bus.rx_rdy) + CR_EXT_W'(lost_r);
    if (bus.tx_frm_sent && (cr_sum != '0)) begin
      cr_sum = cr_sum - CR_EXT_W'(1);
    end
    credit_d = credit_q;
    cur_d    = (cr_sum > CR_EXT_W'(credit_q)) ? credit_q : CREDIT_W'(cr_sum);

    rq_sum = RQ_EXT_W'(pend_q) + RQ_EXT_W'(rdy_src) + RQ_EXT_W'(lost_s)
           - RQ_EXT_W'(rdy_sent);
    pend_d = (rq_sum > RQ_MAX) ? RDY_Q_W'(RQ_MAX) : RDY_Q_W'(rq_sum);

    rdy_def_d = rdy_def_q || (lost_r != '0);
    frm_def_d = frm_def_q || (lost_s != '0);
    ack_d     = bus.credit_reset;

    if (load) begin
      credit_d   = bus.credit;
      cur_d      = bus.credit;
      tfc_d      = '0;
      trc_d      = '0;
      rfc_d      = '0;
      rrc_d      = '0;
      scs_pend_d = 1'b0;
      scr_pend_d = 1'b0;
      pend_d     = '0;
      rdy_def_d  = 1'b0;
      frm_def_d  = 1'b0;
    end

    // Request is held until acked, then re-arbitrated from the updated flags.
    req_d = req_q;
    if (load) begin
      req_d = PRIM_NONE;
    end else if ((req_q == PRIM_NONE) || prim_ack) begin
      if (scr_pend_d)         req_d = PRIM_SCR;
      else if (scs_pend_d)    req_d = PRIM_SCS;
      else if (pend_d != '0)  req_d = PRIM_RDY;
      else                    req_d = PRIM_NONE;
    end
  end

  assign bus.credit_reset_ack = ack_q;
  assign bus.tx_prim_req      = req_q;
  assign bus.tx_allow         = (cur_q != '0);
  assign bus.current_credit   = cur_q;
  assign bus.rdy_deficit      = rdy_def_q;
  assign bus.frm_deficit      = frm_def_q;

endmodule

// File: tb/tb_fc_bb_credit_mgr.sv
// Directed self-checking bench for fc_bb_credit_mgr: credit tracking, BB_SC recovery,
// primitive arbitration and the credit_reset handshake.
module tb_fc_bb_credit_mgr;

  logic clk;
  logic rst_n;
  int unsigned n_chk;
  int unsigned n_err;

  fc_bb_credit_mgr_if #(.CREDIT_W(16), .BBSC_W(4)) ifc ();

  fc_bb_credit_mgr #(.CREDIT_W(16), .BBSC_W(4), .RDY_Q_W(8)) dut (
    .tx_clk         (clk),
    .reset_tx_clk_n (rst_n),
    .bus            (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic reload(input logic [15:0] cr, input logic [3:0] scn);
    ifc.credit_reset = 1'b0;
    step();
    ifc.credit = cr;
    ifc.bb_scn = scn;
    ifc.credit_reset = 1'b1;
    step();
  endtask

  initial begin
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    ifc.credit = 16'd4;
    ifc.bb_scn = '0;
    ifc.credit_reset = 1'b0;
    ifc.tx_frm_sent = 1'b0;
    ifc.rx_rdy = 1'b0;
    ifc.rx_frm_rcv = 1'b0;
    ifc.rx_bb_scs = 1'b0;
    ifc.rx_bb_scr = 1'b0;
    ifc.buf_release = 1'b0;
    ifc.ext_rdy_gen = 1'b0;
    ifc.rdy_gen = 1'b0;
    ifc.tx_prim_ack = 1'b0;
    step();
    step();
    chk("rst_ack", ifc.credit_reset_ack, 0);
    chk("rst_credit", ifc.current_credit, 0);
    chk("rst_allow", ifc.tx_allow, 0);
    chk("rst_req", ifc.tx_prim_req, 0);
    chk("rst_deficits", {ifc.rdy_deficit, ifc.frm_deficit}, 0);
    rst_n = 1'b1;
    ifc.rx_rdy = 1'b1;
    step();
    ifc.rx_rdy = 1'b0;
    chk("no_credit_before_load", ifc.current_credit, 0);

    // credit_reset load with credit=4
    ifc.credit_reset = 1'b1;
    step();
    chk("load_ack", ifc.credit_reset_ack, 1);
    chk("load_credit", ifc.current_credit, 4);
    chk("load_allow", ifc.tx_allow, 1);

    for (int i = 0; i < 4; i++) begin
      ifc.tx_frm_sent = 1'b1;
      step();
    end
    chk("credit_drain", ifc.current_credit, 0);
    chk("allow_zero", ifc.tx_allow, 0);
    step();
    ifc.tx_frm_sent = 1'b0;
    chk("credit_floor", ifc.current_credit, 0);
    ifc.rx_rdy = 1'b1;
    step();
    step();
    chk("credit_two", ifc.current_credit, 2);
    ifc.tx_frm_sent = 1'b1;
    step();
    ifc.tx_frm_sent = 1'b0;
    chk("credit_both", ifc.current_credit, 2);
    step();
    step();
    step();
    ifc.rx_rdy = 1'b0;
    chk("credit_ceiling", ifc.current_credit, 4);
    chk("ack_held", ifc.credit_reset_ack, 1);
    ifc.credit_reset = 1'b0;
    step();
    chk("ack_drop", ifc.credit_reset_ack, 0);

    // Reload with credit=8, bb_scn=2; a frame in the load cycle must be ignored
    ifc.credit = 16'd8;
    ifc.bb_scn = 4'd2;
    ifc.credit_reset = 1'b1;
    ifc.tx_frm_sent = 1'b1;
    step();
    ifc.tx_frm_sent = 1'b0;
    chk("reload_ignores_evt", ifc.current_credit, 8);

    for (int i = 0; i < 4; i++) begin
      ifc.tx_frm_sent = 1'b1;
      step();
    end
    ifc.tx_frm_sent = 1'b0;
    chk("credit_after4", ifc.current_credit, 4);
    chk("scs_req", ifc.tx_prim_req, 2);
    step();
    step();
    step();
    chk("scs_req_held", ifc.tx_prim_req, 2);
    ifc.tx_prim_ack = 1'b1;
    step();
    ifc.tx_prim_ack = 1'b0;
    chk("scs_req_clear", ifc.tx_prim_req, 0);

    // BB_SC_R recovery: rrc=1 -> 3 lost R_RDYs
    ifc.rx_rdy = 1'b1;
    step();
    ifc.rx_rdy = 1'b0;
    chk("credit_five", ifc.current_credit, 5);
    ifc.rx_bb_scr = 1'b1;
    step();
    ifc.rx_bb_scr = 1'b0;
    chk("scr_recover", ifc.current_credit, 8);
    chk("rdy_deficit", ifc.rdy_deficit, 1);
    chk("frm_deficit_clear", ifc.frm_deficit, 0);

    // BB_SC_S recovery: rfc=2 -> 2 owed R_RDYs
    ifc.rx_frm_rcv = 1'b1;
    step();
    step();
    ifc.rx_frm_rcv = 1'b0;
    ifc.rx_bb_scs = 1'b1;
    step();
    ifc.rx_bb_scs = 1'b0;
    chk("scs_rdy_req", ifc.tx_prim_req, 1);
    chk("frm_deficit", ifc.frm_deficit, 1);
    ifc.tx_prim_ack = 1'b1;
    step();
    chk("rdy_req_second", ifc.tx_prim_req, 1);
    step();
    ifc.tx_prim_ack = 1'b0;
    chk("rdy_req_done", ifc.tx_prim_req, 0);
    ifc.buf_release = 1'b1;
    step();
    step();
    ifc.buf_release = 1'b0;
    chk("buf_release_req", ifc.tx_prim_req, 1);
    ifc.tx_prim_ack = 1'b1;
    step();
    step();
    ifc.tx_prim_ack = 1'b0;
    chk("trc_wrap_scr", ifc.tx_prim_req, 3);
    ifc.tx_prim_ack = 1'b1;
    step();
    ifc.tx_prim_ack = 1'b0;
    chk("scr_acked", ifc.tx_prim_req, 0);

    // bb_scn=0: recovery disabled, BB_SC_S ignored
    reload(16'd8, 4'd0);
    ifc.rx_frm_rcv = 1'b1;
    step();
    ifc.rx_frm_rcv = 1'b0;
    ifc.rx_bb_scs = 1'b1;
    step();
    ifc.rx_bb_scs = 1'b0;
    chk("scn0_req", ifc.tx_prim_req, 0);
    chk("scn0_frm_deficit", ifc.frm_deficit, 0);

    // External R_RDY source, priority scr over pending R_RDY
    reload(16'd8, 4'd2);
    chk("reload_deficit_clear", ifc.rdy_deficit, 0);
    ifc.ext_rdy_gen = 1'b1;
    ifc.buf_release = 1'b1;
    step();
    ifc.buf_release = 1'b0;
    chk("ext_ignores_buf", ifc.tx_prim_req, 0);
    ifc.rdy_gen = 1'b1;
    for (int i = 0; i < 4; i++) step();
    ifc.rdy_gen = 1'b0;
    chk("ext_rdy_req", ifc.tx_prim_req, 1);
    ifc.tx_prim_ack = 1'b1;
    for (int i = 0; i < 3; i++) step();
    ifc.rdy_gen = 1'b1;
    step();
    ifc.rdy_gen = 1'b0;
    ifc.tx_prim_ack = 1'b0;
    chk("scr_priority", ifc.tx_prim_req, 3);
    ifc.tx_prim_ack = 1'b1;
    step();
    ifc.tx_prim_ack = 1'b0;
    chk("rdy_after_scr", ifc.tx_prim_req, 1);
    chk("credit_untouched", ifc.current_credit, 8);

    // Reset mid-request
    rst_n = 1'b0;
    step();
    chk("midrst_req", ifc.tx_prim_req, 0);
    chk("midrst_credit", ifc.current_credit, 0);
    chk("midrst_allow", ifc.tx_allow, 0);
    chk("midrst_ack", ifc.credit_reset_ack, 0);
    rst_n = 1'b1;
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
